// File: rtl/tm1637_frame_sequencer.sv
// TM1637 frame sequencer: walks the fixed START/BYTE/STOP command list for one
// display refresh and hands each command to the serial byte engine.
module tm1637_frame_sequencer #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    update_req,
  input  logic [8*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    busy,
  output logic                    done,
  output logic                    nak_err,
  output logic                    timeout_err,
  output logic                    eng_cmd_valid,
  output logic [1:0]              eng_cmd,
  output logic [7:0]              eng_data,
  input  logic                    eng_ready,
  input  logic                    eng_done,
  input  logic                    eng_nak
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 9);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] IDX_DSTOP  = IDX_W'(NUM_DIGITS + 5);
  localparam logic [IDX_W-1:0] IDX_CSTART = IDX_W'(NUM_DIGITS + 6);
  localparam logic [IDX_W-1:0] IDX_CBYTE  = IDX_W'(NUM_DIGITS + 7);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS + 8);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_BYTE  = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_e;

  // {cmd, data} for a given list position, built from the shadowed frame content.
  function automatic logic [9:0] cmd_at(input logic [IDX_W-1:0]        idx,
                                        input logic [8*NUM_DIGITS-1:0] dig,
                                        input logic [7:0]              ctrl);
    logic [9:0] c;
    c = {CMD_BYTE, 8'h00};
    if (idx == '0 || idx == IDX_W'(3) || idx == IDX_CSTART) begin
      c = {CMD_START, 8'h00};
    end else if (idx == IDX_W'(2) || idx == IDX_DSTOP || idx == IDX_LAST) begin
      c = {CMD_STOP, 8'h00};
    end else if (idx == IDX_W'(1)) begin
      c = {CMD_BYTE, 8'h40};
    end else if (idx == IDX_W'(4)) begin
      c = {CMD_BYTE, 8'hC0};
    end else if (idx == IDX_CBYTE) begin
      c = {CMD_BYTE, ctrl};
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k + 5)) c = {CMD_BYTE, dig[8*k +: 8]};
      end
    end
    return c;
  endfunction

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    nak_flag_q, nak_flag_d;
  logic                    cur_byte_q, cur_byte_d;
  logic [8*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]              ctrl_q, ctrl_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    nak_err_q, nak_err_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    valid_q, valid_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [7:0]              data_q, data_d;
  logic [9:0]              nxt_cmd;
  logic                    nak_now;

  assign idx_inc = idx_q + IDX_W'(1);
  assign nxt_cmd = cmd_at(idx_inc, dig_q, ctrl_q);
  assign nak_now = eng_nak & cur_byte_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    nak_flag_d    = nak_flag_q;
    cur_byte_d    = cur_byte_q;
    dig_d         = dig_q;
    ctrl_d        = ctrl_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    nak_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    valid_d       = valid_q;
    cmd_d         = cmd_q;
    data_d        = data_q;

    if (state_q != S_IDLE && update_req) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (update_req || pending_q) begin
          dig_d      = digits;
          ctrl_d     = {4'h8, display_on, brightness};
          pending_d  = 1'b0;
          nak_flag_d = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b1;
          cmd_d      = CMD_START;
          data_d     = 8'h00;
          cur_byte_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_ready) begin
          valid_d = 1'b0;
          cmd_d   = CMD_START;
          data_d  = 8'h00;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          if (nak_now) nak_flag_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            nak_err_d = nak_flag_q | nak_now;
            state_d   = S_FIN;
          end else begin
            idx_d      = idx_inc;
            valid_d    = 1'b1;
            cmd_d      = nxt_cmd[9:8];
            data_d     = nxt_cmd[7:0];
            cur_byte_d = (nxt_cmd[9:8] == CMD_BYTE);
            state_d    = S_ISSUE;
          end
        end else if (cnt_q == CNT_MAX) begin
          done_d        = 1'b1;
          busy_d        = 1'b0;
          nak_err_d     = nak_flag_q;
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        nak_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      nak_flag_q    <= 1'b0;
      cur_byte_q    <= 1'b0;
      dig_q         <= '0;
      ctrl_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      nak_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      valid_q       <= 1'b0;
      cmd_q         <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      nak_flag_q    <= nak_flag_d;
      cur_byte_q    <= cur_byte_d;
      dig_q         <= dig_d;
      ctrl_q        <= ctrl_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      nak_err_q     <= nak_err_d;
      timeout_err_q <= timeout_err_d;
      valid_q       <= valid_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign nak_err       = nak_err_q;
  assign timeout_err   = timeout_err_q;
  assign eng_cmd_valid = valid_q;
  assign eng_cmd       = cmd_q;
  assign eng_data      = data_q;

endmodule

// File: tb/tb_tm1637_frame_sequencer.sv
// Bench for tm1637_frame_sequencer: a behavioural byte engine checks every
// accepted command against an expected-command queue filled per requested frame.
`timescale 1ns/1ps
module tb_tm1637_frame_sequencer;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        update_req = 1'b0;
  logic [31:0] digits = '0;
  logic [2:0]  brightness = '0;
  logic        display_on = 1'b0;
  logic        busy, done, nak_err, timeout_err, eng_cmd_valid;
  logic [1:0]  eng_cmd;
  logic [7:0]  eng_data;
  logic        eng_ready = 1'b1;
  logic        eng_done = 1'b0;
  logic        eng_nak = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];
  int   acc_cnt = 0;
  int   stall_at = -1;
  int   stall_rem = 0;
  int   stall_seen = 0;
  int   nak_idx = -1;
  int   withhold_from = 99;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   last_accept_cyc = 0;
  logic nak_pend = 1'b0;

  tm1637_frame_sequencer #(
    .NUM_DIGITS (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .update_req   (update_req),
    .digits       (digits),
    .brightness   (brightness),
    .display_on   (display_on),
    .busy         (busy),
    .done         (done),
    .nak_err      (nak_err),
    .timeout_err  (timeout_err),
    .eng_cmd_valid(eng_cmd_valid),
    .eng_cmd      (eng_cmd),
    .eng_data     (eng_data),
    .eng_ready    (eng_ready),
    .eng_done     (eng_done),
    .eng_nak      (eng_nak)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  // Engine model: completes each accepted command 2 cycles after acceptance.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk_50M);
      eng_done = 1'b0;
      eng_nak  = 1'b0;
      if (rst) begin
        done_cnt = 0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          eng_done      = 1'b1;
          eng_nak       = nak_pend;
          last_done_cyc = cyc;
        end
      end
      eng_ready = 1'b1;
      if (!rst && eng_cmd_valid === 1'b1) begin
        if (stall_rem > 0 && acc_cnt == stall_at) begin
          eng_ready = 1'b0;
          stall_rem--;
          stall_seen++;
          vectors++;
          if ({eng_cmd, eng_data} !== {2'b01, 8'hC0}) begin
            miscompares++;
            $display("FAIL stall_hold: got cmd=%b data=%h, want cmd=01 data=c0", eng_cmd, eng_data);
          end
        end else begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_cmd: unexpected cmd=%b data=%h, want no command", eng_cmd, eng_data);
          end else begin
            exp = exp_q.pop_front();
            if ({eng_cmd, eng_data} !== exp) begin
              miscompares++;
              $display("FAIL sb_cmd[%0d]: got cmd=%b data=%h, want cmd=%b data=%h",
                       acc_cnt, eng_cmd, eng_data, exp[9:8], exp[7:0]);
            end
          end
          if (acc_cnt < withhold_from) begin
            done_cnt = 2;
            nak_pend = (acc_cnt == nak_idx);
          end
          acc_cnt++;
          last_accept_cyc = cyc;
        end
      end
    end
  end

  task automatic push_frame(input logic [31:0] d, input logic [2:0] b, input logic on);
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'h40});
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'hC0});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, d[8*i +: 8]});
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 4'h8, on, b});
    exp_q.push_back({2'b10, 8'h00});
  endtask

  task automatic start_frame(input logic [31:0] d, input logic [2:0] b, input logic on);
    @(negedge clk_50M);
    digits     = d;
    brightness = b;
    display_on = on;
    update_req = 1'b1;
    push_frame(d, b, on);
    @(negedge clk_50M);
    update_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_50M);
    vectors++;
    if ({busy, done, nak_err, timeout_err, eng_cmd_valid, eng_cmd, eng_data} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {busy, done, nak_err, timeout_err, eng_cmd_valid, eng_cmd, eng_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    acc_cnt = 0;
    start_frame(32'h3F065B4F, 3'd7, 1'b1);
    vectors++;
    if ({eng_cmd_valid, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL basic_latency: got valid/busy=%b, want 11", {eng_cmd_valid, busy});
    end
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_done: got no done, want done within bound");
    end
    vectors++;
    if ({nak_err, timeout_err, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL basic_flags: got nak/to/busy=%b, want 000", {nak_err, timeout_err, busy});
    end
    vectors++;
    if (cyc !== last_done_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_done_latency: got cycle %0d, want %0d", cyc, last_done_cyc + 1);
    end
    vectors++;
    if (acc_cnt !== 13 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL basic_count: got %0d accepts/%0d left, want 13/0", acc_cnt, exp_q.size());
    end
    @(negedge clk_50M);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_latch;
    bit ok;
    acc_cnt = 0;
    start_frame(32'h3F065B4F, 3'd2, 1'b0);
    repeat (3) @(negedge clk_50M);
    digits     = 32'hFFFF_FFFF;
    brightness = 3'd7;
    display_on = 1'b1;
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL latch_done: got ok=%0d nak/to=%b, want ok=1 00", ok, {nak_err, timeout_err});
    end
    vectors++;
    if (acc_cnt !== 13 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL latch_count: got %0d accepts/%0d left, want 13/0", acc_cnt, exp_q.size());
    end
  endtask

  task automatic test_stall;
    bit ok;
    acc_cnt    = 0;
    stall_at   = 4;
    stall_rem  = 50;
    stall_seen = 0;
    start_frame(32'h12345678, 3'd5, 1'b1);
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_done: got ok=%0d nak/to=%b, want ok=1 00", ok, {nak_err, timeout_err});
    end
    vectors++;
    if (stall_seen !== 50 || acc_cnt !== 13 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_count: got stall=%0d accepts=%0d left=%0d, want 50/13/0",
               stall_seen, acc_cnt, exp_q.size());
    end
    stall_at = -1;
  endtask

  task automatic test_nak;
    bit ok;
    acc_cnt = 0;
    nak_idx = 6;
    start_frame(32'h3F065B4F, 3'd7, 1'b1);
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL nak_flag: got ok=%0d nak/to=%b, want ok=1 10", ok, {nak_err, timeout_err});
    end
    vectors++;
    if (acc_cnt !== 13 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL nak_count: got %0d accepts/%0d left, want 13/0", acc_cnt, exp_q.size());
    end
    nak_idx = -1;
    acc_cnt = 0;
    start_frame(32'h3F065B4F, 3'd7, 1'b1);
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL nak_clear: got ok=%0d nak/to=%b, want ok=1 00", ok, {nak_err, timeout_err});
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int extra;
    acc_cnt       = 0;
    withhold_from = 3;
    start_frame(32'hA1B2C3D4, 3'd1, 1'b1);
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL timeout_flag: got ok=%0d nak/to/busy=%b, want ok=1 010",
               ok, {nak_err, timeout_err, busy});
    end
    vectors++;
    if (cyc !== last_accept_cyc + 17) begin
      miscompares++;
      $display("FAIL timeout_cycles: got done at %0d, want %0d", cyc, last_accept_cyc + 17);
    end
    vectors++;
    if (acc_cnt !== 4) begin
      miscompares++;
      $display("FAIL timeout_accepts: got %0d, want 4", acc_cnt);
    end
    exp_q.delete();
    extra = 0;
    repeat (20) begin
      @(negedge clk_50M);
      if (eng_cmd_valid !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL timeout_quiet: got %0d valid cycles, want 0", extra);
    end
    withhold_from = 99;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int extra;
    acc_cnt = 0;
    start_frame(32'h3F065B4F, 3'd7, 1'b1);
    repeat (5) @(negedge clk_50M);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50M);
      update_req = 1'b1;
      @(negedge clk_50M);
      update_req = 1'b0;
      repeat (2) @(negedge clk_50M);
    end
    digits     = 32'h7F6D6677;
    brightness = 3'd4;
    display_on = 1'b1;
    push_frame(32'h7F6D6677, 3'd4, 1'b1);
    wait_done(ok);
    vectors++;
    if (!ok || {nak_err, timeout_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_done1: got ok=%0d nak/to=%b, want ok=1 00", ok, {nak_err, timeout_err});
    end
    @(negedge clk_50M);
    vectors++;
    if ({eng_cmd_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: got valid/busy/done=%b, want 000", {eng_cmd_valid, busy, done});
    end
    @(negedge clk_50M);
    vectors++;
    if ({eng_cmd_valid, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_restart: got valid/busy=%b, want 11", {eng_cmd_valid, busy});
    end
    wait_done(ok);
    vectors++;
    if (!ok || acc_cnt !== 26 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL b2b_count: got ok=%0d accepts=%0d left=%0d, want 1/26/0",
               ok, acc_cnt, exp_q.size());
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk_50M);
      if (eng_cmd_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL b2b_single_extra: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int extra;
    acc_cnt = 0;
    start_frame(32'h3F065B4F, 3'd7, 1'b1);
    repeat (8) @(negedge clk_50M);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk_50M);
    vectors++;
    if ({busy, done, nak_err, timeout_err, eng_cmd_valid, eng_cmd, eng_data} !== 15'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %b, want all zero",
               {busy, done, nak_err, timeout_err, eng_cmd_valid, eng_cmd, eng_data});
    end
    @(negedge clk_50M);
    rst = 1'b0;
    exp_q.delete();
    extra = 0;
    repeat (20) begin
      @(negedge clk_50M);
      if (done !== 1'b0 || eng_cmd_valid !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: got %0d done/valid cycles, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latch();
    test_stall();
    test_nak();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
